// File: rtl/fir_tdm.sv
// Multi-channel FIR filter sharing one multiply-accumulate unit across all taps and channels.
// Each accepted sample takes TAPS MAC cycles plus one round/saturate cycle.
module fir_tdm #(
   parameter  int DIN_W    = 10,
   parameter  int COEF_W   = 8,
   parameter  int TAPS     = 16,
   parameter  int CHANNELS = 4,
   parameter  int SHIFT    = 5,
   parameter  int DOUT_W   = 11,
   localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int TA_W     = (TAPS > 1) ? $clog2(TAPS) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [DIN_W-1:0]  din,
   input  logic        [CH_W-1:0]   din_ch,
   input  logic                     din_valid,
   output logic                     din_ready,
   input  logic                     coef_we,
   input  logic        [TA_W-1:0]   coef_addr,
   input  logic signed [COEF_W-1:0] coef_data,
   output logic signed [DOUT_W-1:0] dout,
   output logic        [CH_W-1:0]   dout_ch,
   output logic                     dout_valid
);

   localparam int PROD_W = DIN_W + COEF_W;
   localparam int ACC_W  = DIN_W + COEF_W + TA_W;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MAC  = 2'd1;
   localparam logic [1:0] S_RND  = 2'd2;

   localparam logic [CH_W:0]     CH_LIM  = (CH_W+1)'(CHANNELS);
   localparam logic [TA_W:0]     TAP_LIM = (TA_W+1)'(TAPS);
   localparam logic [TA_W-1:0]   K_LAST  = TA_W'(TAPS-1);
   localparam logic signed [ACC_W:0] RND_BIAS = (ACC_W+1)'(1) << (SHIFT-1);
   localparam logic signed [ACC_W:0] SAT_MAX  = (ACC_W+1)'((2**(DOUT_W-1))-1);
   localparam logic signed [ACC_W:0] SAT_MIN  = (ACC_W+1)'(-(2**(DOUT_W-1)));

   // Round half up: bias then arithmetic shift, one bit wider so the bias cannot overflow.
   function automatic logic signed [ACC_W:0] round_acc(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W:0] t;
      t = $signed({a[ACC_W-1], a}) + RND_BIAS;
      return t >>> SHIFT;
   endfunction

   function automatic logic signed [DOUT_W-1:0] saturate(input logic signed [ACC_W:0] r);
      if (r > SAT_MAX)
         return SAT_MAX[DOUT_W-1:0];
      else if (r < SAT_MIN)
         return SAT_MIN[DOUT_W-1:0];
      else
         return r[DOUT_W-1:0];
   endfunction

   logic [1:0]               state;
   logic [CH_W-1:0]          ch;
   logic [TA_W-1:0]          k;
   logic signed [ACC_W-1:0]  acc;
   logic signed [COEF_W-1:0] coef [TAPS];
   logic signed [DIN_W-1:0]  hist [CHANNELS][TAPS];

   logic signed [PROD_W-1:0] coef_x;
   logic signed [PROD_W-1:0] hist_x;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic                     accept;
   logic                     sample_ok;
   logic                     coef_ok;

   assign din_ready = (state == S_IDLE);
   assign accept    = din_valid & din_ready;
   assign sample_ok = ({1'b0, din_ch} < CH_LIM);
   assign coef_ok   = ({1'b0, coef_addr} < TAP_LIM);

   assign coef_x   = $signed({{DIN_W{coef[k][COEF_W-1]}}, coef[k]});
   assign hist_x   = $signed({{COEF_W{hist[ch][k][DIN_W-1]}}, hist[ch][k]});
   assign prod     = coef_x * hist_x;
   assign prod_ext = $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         ch         <= '0;
         k          <= '0;
         acc        <= '0;
         dout       <= '0;
         dout_ch    <= '0;
         dout_valid <= 1'b0;
         for (int t = 0; t < TAPS; t++) begin
            coef[t] <= '0;
            for (int c = 0; c < CHANNELS; c++)
               hist[c][t] <= '0;
         end
      end else begin
         dout_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               // A write landing with an accept is visible from the first MAC cycle.
               if (coef_we && coef_ok)
                  coef[coef_addr] <= coef_data;
               if (accept && sample_ok) begin
                  for (int t = TAPS-1; t > 0; t--)
                     hist[din_ch][t] <= hist[din_ch][t-1];
                  hist[din_ch][0] <= din;
                  ch    <= din_ch;
                  acc   <= '0;
                  k     <= '0;
                  state <= S_MAC;
               end
            end
            S_MAC: begin
               acc <= acc + prod_ext;
               k   <= k + TA_W'(1);
               if (k == K_LAST)
                  state <= S_RND;
            end
            S_RND: begin
               dout       <= saturate(round_acc(acc));
               dout_ch    <= ch;
               dout_valid <= 1'b1;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/fir_tdm.md
# fir_tdm

Time-multiplexed, multi-channel, parametrised FIR filter with a single shared multiply-accumulate unit, runtime-programmable coefficients, round-half-up scaling and output saturation. It is the next generation of the fixed 16-tap `fir_sync` filter. It serves several interleaved sample streams from one datapath behind a valid/ready input handshake, and emits one filtered sample per accepted input, tagged with its channel.

## Interface
- `DIN_W`, 10: signed input sample width.
- `COEF_W`, 8: signed coefficient width.
- `TAPS`, 16: filter length; must be ≥2.
- `CHANNELS`, 4: number of independent channels (delay lines).
- `SHIFT`, 5: right shift applied to the accumulator before output; must be ≥1.
- `DOUT_W`, 11: signed output width.
- Derived: `CH_W` = max(1, clog2(CHANNELS)); `TA_W` = max(1, clog2(TAPS)); `ACC_W` = DIN_W+COEF_W+TA_W.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `din`  in  DIN_W  signed input sample.
- `din_ch`  in  CH_W  channel of `din`.
- `din_valid`  in  1  `din`/`din_ch` valid.
- `din_ready`  out  1  block can accept a sample.
- `coef_we`  in  1  coefficient write strobe.
- `coef_addr`  in  TA_W  tap index k.
- `coef_data`  in  COEF_W  signed coefficient h[k].
- `dout`  out  DOUT_W  signed filtered sample.
- `dout_ch`  out  CH_W  channel of `dout`.
- `dout_valid`  out  1  one-cycle pulse, `dout`/`dout_ch` valid.

## Operation
- Storage: `coef[TAPS]`, shared by all channels; `hist[CHANNELS][TAPS]`, per channel; `hist[c][0]` holds the newest sample.
- Function per accepted sample on channel c: y = Σ(k=0..TAPS-1) coef[k]·hist[c][k], computed after the shift-in.
- States:
  - IDLE: `din_ready`=1. On `din_valid`&`din_ready`, shift `hist[din_ch]` by one (the oldest sample is dropped), write `din` to index 0, latch the channel, clear `acc` and k, then go to MAC.
  - MAC: one tap per cycle, `acc += coef[k]*hist[ch][k]`, k++. After tap TAPS-1, go to RND.
  - RND: compute r = (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift, round half up). Saturate r to [-2^(DOUT_W-1), 2^(DOUT_W-1)-1]. Register r into `dout` and the channel into `dout_ch`, set `dout_valid`, then go to IDLE.
- Arithmetic: all signed. `acc` is ACC_W bits wide and cannot overflow. The rounding add is performed at ACC_W+1 bits.
- `din_ch` ≥ CHANNELS: the handshake completes and the sample is discarded. No state change and no output.
- Coefficient writes:
  - Accepted only in IDLE.
  - `coef_we` in MAC or RND is ignored (dropped).
  - A write in the same IDLE cycle as an input accept takes effect for that sample.
- `coef_addr` ≥ TAPS: write ignored.

## Timing
- Reset (async assert, effect immediate): state IDLE, `din_ready`=1, `dout`=0, `dout_ch`=0, `dout_valid`=0, `acc`=0, all `hist` and `coef` entries =0.
- Reset asserted mid-MAC/RND: the operation is aborted and no `dout_valid` is issued for it.
- Let E0 be the accepting edge.
  - MAC accumulates at edges E1..E_TAPS.
  - Output is registered at E_TAPS+1; `dout_valid` is high for exactly the cycle after E_TAPS+1.
  - Latency is TAPS+1 cycles.
- `din_ready` is low from after E0 until after E_TAPS+1. The next accept is at E_TAPS+2 at the earliest, giving a throughput of one sample per TAPS+2 cycles.
- `dout`/`dout_ch` hold their values until the next output.
- No back-pressure on the output; the consumer must take the output during the pulse.

## Test plan
- Reset: hold `rst` 3 cycles with `din_valid`=1 → `din_ready`=1, `dout`=0, `dout_valid`=0. After release, first accept with all coefs 0 → `dout`=0, `dout_valid` pulse exactly 17 cycles after accept.
- Impulse/delay:
  - Setup: coef[3]=64, all others 0; feed channel 1 with 10, 0, 0, 0.
  - Required outputs: 0, 0, 0, 20, all with `dout_ch`=1.
  - Setup: coef[0]=32; feed 100 → `dout`=100.
- Channel isolation:
  - Setup: coef[0]=coef[1]=32; feed interleaved ch0=100, ch2=-100, ch0=100, ch2=-100.
  - Required outputs: 100, -100, 200, -200, with matching `dout_ch`.
  - Channel 3 stays untouched: feeding 0 on ch3 → 0.
- Saturation: all coefs 127; feed 511 sixteen times on ch3 → final `dout`=1023. Repeat with -512 on ch2 → -1024.
- Rounding: coef[0]=1 only, SHIFT=5; din 16 → 1, din 15 → 0, din -16 → 0, din -17 → -1.
- Busy-time events:
  - Write coef[0]=50 at 5 cycles after an accept → ignored; the output uses the old coefficient.
  - Assert `rst` 5 cycles after an accept → no `dout_valid`, `din_ready`=1 immediately, and a subsequent impulse on coef[1] shows zeroed history.
